// File: rtl/muldiv_iter_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: one shared FSM with valid/ready on both sides.
// Optional macro MULDIV_EARLY_TERM_EN ends multiply RUN early and skips RUN for |a|<|b| divides.
module muldiv_iter_unit #(
  parameter int WIDTH              = 32,
  parameter int MUL_BITS_PER_CYCLE = 2,
  parameter int DIV_BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy
);
  localparam int W     = WIDTH;
  localparam int MB    = MUL_BITS_PER_CYCLE;
  localparam int DB    = DIV_BITS_PER_CYCLE;
  localparam int MUL_N = W / MB;
  localparam int DIV_N = W / DB;
  localparam int CW    = $clog2(W + 1);
  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_N - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV_N - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e         state_q;
  logic           div_q;
  logic           neg_lo_q;
  logic           neg_hi_q;
  logic [CW-1:0]  cnt_q;
  logic [2*W-1:0] acc_q;
  logic [2*W-1:0] mcand_q;
  logic [W-1:0]   opb_q;
  logic [W-1:0]   hi_q;
  logic [W-1:0]   lo_q;
  logic           out_valid_q;

  function automatic logic [W-1:0] neg_f(input logic [W-1:0] v);
    return ~v + {{(W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*W-1:0] neg2_f(input logic [2*W-1:0] v);
    return ~v + {{(2*W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [W-1:0] abs_f(input logic [W-1:0] v, input logic is_signed);
    if (is_signed && v[W-1]) begin
      return neg_f(v);
    end else begin
      return v;
    end
  endfunction

  logic           sgn_a_s;
  logic           sgn_b_s;
  logic [W-1:0]   abs_a_s;
  logic [W-1:0]   abs_b_s;
  logic           b_zero_s;
  logic           mul_last_s;
  logic           div_skip_s;
  logic [2*W-1:0] mul_acc_d;
  logic [2*W-1:0] mul_mcand_d;
  logic [W-1:0]   mul_mpl_d;
  logic [W-1:0]   div_rem_s;
  logic [W-1:0]   div_quo_s;
  logic [W:0]     div_trial_s;
  logic [2*W-1:0] div_acc_d;
  logic [2*W-1:0] fix_prod_s;
  logic [W-1:0]   fix_quo_s;
  logic [W-1:0]   fix_rem_s;

  assign sgn_a_s  = op[0] & a[W-1];
  assign sgn_b_s  = op[0] & b[W-1];
  assign abs_a_s  = abs_f(a, op[0]);
  assign abs_b_s  = abs_f(b, op[0]);
  assign b_zero_s = (b == {W{1'b0}});

  // Multiply step: retire MB multiplier LSBs, add the shifted multiplicand for each set bit.
  always_comb begin
    mul_acc_d   = acc_q;
    mul_mcand_d = mcand_q;
    mul_mpl_d   = opb_q;
    for (int i = 0; i < MB; i++) begin
      if (mul_mpl_d[0]) begin
        mul_acc_d = mul_acc_d + mul_mcand_d;
      end else begin
        mul_acc_d = mul_acc_d;
      end
      mul_mcand_d = {mul_mcand_d[2*W-2:0], 1'b0};
      mul_mpl_d   = {1'b0, mul_mpl_d[W-1:1]};
    end
  end

  // Divide step: DB chained restoring iterations; acc holds {remainder, dividend/quotient}.
  always_comb begin
    div_rem_s   = acc_q[2*W-1:W];
    div_quo_s   = acc_q[W-1:0];
    div_trial_s = {(W+1){1'b0}};
    for (int i = 0; i < DB; i++) begin
      div_trial_s = {div_rem_s, div_quo_s[W-1]} - {1'b0, opb_q};
      if (div_trial_s[W]) begin
        div_rem_s = {div_rem_s[W-2:0], div_quo_s[W-1]};
      end else begin
        div_rem_s = div_trial_s[W-1:0];
      end
      div_quo_s = {div_quo_s[W-2:0], ~div_trial_s[W]};
    end
    div_acc_d = {div_rem_s, div_quo_s};
  end

  // Sign correction applied in FIX; the flags are only ever set for signed ops.
  always_comb begin
    fix_prod_s = neg_lo_q ? neg2_f(acc_q) : acc_q;
    fix_quo_s  = neg_lo_q ? neg_f(acc_q[W-1:0]) : acc_q[W-1:0];
    fix_rem_s  = neg_hi_q ? neg_f(acc_q[2*W-1:W]) : acc_q[2*W-1:W];
  end

`ifdef MULDIV_EARLY_TERM_EN
  assign mul_last_s = (cnt_q == MUL_LAST) || (mul_mpl_d == {W{1'b0}});
  assign div_skip_s = (abs_a_s < abs_b_s);
`else
  assign mul_last_s = (cnt_q == MUL_LAST);
  assign div_skip_s = 1'b0;
`endif

  // Control FSM and datapath registers; flush beats every state transition.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      div_q       <= 1'b0;
      neg_lo_q    <= 1'b0;
      neg_hi_q    <= 1'b0;
      cnt_q       <= {CW{1'b0}};
      acc_q       <= {(2*W){1'b0}};
      mcand_q     <= {(2*W){1'b0}};
      opb_q       <= {W{1'b0}};
      hi_q        <= {W{1'b0}};
      lo_q        <= {W{1'b0}};
      out_valid_q <= 1'b0;
    end else if (flush) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            div_q    <= op[1];
            neg_lo_q <= sgn_a_s ^ sgn_b_s;
            neg_hi_q <= sgn_a_s;
            cnt_q    <= {CW{1'b0}};
            opb_q    <= abs_b_s;
            mcand_q  <= {{W{1'b0}}, abs_a_s};
            if (op[1] && b_zero_s) begin
              hi_q        <= a;
              lo_q        <= {W{1'b1}};
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else if (op[1] && div_skip_s) begin
              acc_q   <= {abs_a_s, {W{1'b0}}};
              state_q <= S_FIX;
            end else begin
              acc_q   <= op[1] ? {{W{1'b0}}, abs_a_s} : {(2*W){1'b0}};
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          cnt_q <= cnt_q + CNT_ONE;
          if (div_q) begin
            acc_q <= div_acc_d;
            if (cnt_q == DIV_LAST) begin
              state_q <= S_FIX;
            end
          end else begin
            acc_q   <= mul_acc_d;
            mcand_q <= mul_mcand_d;
            opb_q   <= mul_mpl_d;
            if (mul_last_s) begin
              state_q <= S_FIX;
            end
          end
        end
        S_FIX: begin
          if (div_q) begin
            hi_q <= fix_rem_s;
            lo_q <= fix_quo_s;
          end else begin
            hi_q <= fix_prod_s[2*W-1:W];
            lo_q <= fix_prod_s[W-1:0];
          end
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE) && !flush;
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Scoreboard bench for muldiv_iter_unit: directed cases plus randomized ops against an arithmetic model.
module tb_muldiv_iter_unit;
  localparam int W     = 32;
  localparam int MB    = 2;
  localparam int DB    = 1;
  localparam int MUL_N = W / MB;
  localparam int DIV_N = W / DB;

  logic          clk = 1'b0;
  logic          resetn;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;
  logic          busy;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           lat;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  bit   prev_ov = 1'b0;

  muldiv_iter_unit dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .hi(hi), .lo(lo), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] absv(input logic [W-1:0] v, input logic s);
    logic [W-1:0] z;
    z = '0;
    return (s && v[W-1]) ? z - v : v;
  endfunction

  // Reference result {hi, lo} computed with plain 64-bit arithmetic.
  function automatic logic [2*W-1:0] ref_f(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx, sy;
    logic [2*W-1:0] ux, uy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    if (o[1] && y == 32'd0) return {x, 32'hFFFF_FFFF};
    case (o)
      2'b00:   return ux * uy;
      2'b01:   return 64'(sx * sy);
      2'b10:   return {x % y, x / y};
      default: return {32'(sx % sy), 32'(sx / sy)};
    endcase
  endfunction

  function automatic int lat_f(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef MULDIV_EARLY_TERM_EN
    int k;
    int c;
`endif
    if (o[1]) begin
      if (y == 32'd0) return 1;
`ifdef MULDIV_EARLY_TERM_EN
      if (absv(x, o[0]) < absv(y, o[0])) return 2;
`endif
      return DIV_N + 2;
    end
`ifdef MULDIV_EARLY_TERM_EN
    k = 0;
    for (int i = 0; i < W; i++) if (absv(y, o[0]) >> i != 32'd0) k = i + 1;
    c = (k + MB - 1) / MB;
    if (c < 1) c = 1;
    return c + 2;
`else
    return MUL_N + 2;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Monitor: compare every presented result against the scoreboard head.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!resetn) begin
        prev_ov = 1'b0;
      end else begin
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            if (!prev_ov) begin
              tests++; fails++;
              $display("FAIL unexpected_result: got out_valid=1 hi=%h lo=%h, required no result", hi, lo);
            end
          end else begin
            e = exp_q[0];
            if (!prev_ov) begin
              tests++;
              if (cyc - acc_cyc != e.lat) begin
                fails++;
                $display("FAIL latency: got %0d, required %0d", cyc - acc_cyc, e.lat);
              end
            end
            tests++;
            if (hi !== e.hi || lo !== e.lo) begin
              fails++;
              $display("FAIL result: got hi=%h lo=%h, required hi=%h lo=%h", hi, lo, e.hi, e.lo);
            end
            tests++;
            if (in_ready !== 1'b0) begin
              fails++;
              $display("FAIL in_ready_done: got %b, required 0", in_ready);
            end
            if (out_ready) void'(exp_q.pop_front());
          end
        end
        if (in_valid && in_ready) acc_cyc = cyc;
        prev_ov = out_valid;
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    bit done;
    done = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; op = o; a = x; b = y;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL accept_timeout: got in_ready=0 for 100 cycles, required 1");
    end
  endtask

  // Push expectation, issue, then drain with the chosen out_ready policy.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] ehi, input logic [W-1:0] elo,
                        input bit rnd_ready, input int hold_n);
    exp_t e;
    int held;
    held = 0;
    e.hi = ehi; e.lo = elo; e.lat = lat_f(o, x, y);
    exp_q.push_back(e);
    out_ready = (hold_n > 0) ? 1'b0 : 1'b1;
    issue(o, x, y);
    for (int c = 0; c < 300 && exp_q.size() != 0; c++) begin
      @(posedge clk); #1;
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      else if (out_valid && held < hold_n) begin out_ready = 1'b0; held++; end
      else out_ready = 1'b1;
    end
    if (exp_q.size() != 0) begin
      tests++; fails++;
      $display("FAIL result_timeout: got no result in 300 cycles, required hi=%h lo=%h", ehi, elo);
      exp_q.delete();
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [1:0]   ro;
    logic [W-1:0] ra, rb;
    logic [63:0]  r;
    bit           seen;
    resetn = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    op = 2'b00; a = '0; b = '0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("reset_state", {hi, lo}, 64'd0);
    check("reset_flags", {61'd0, out_valid, busy, in_ready}, 64'd1);

    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0);
    run_op(2'b01, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 0);
    run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 0);
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0);
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 0);
    run_op(2'b10, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b0, 0);
    run_op(2'b10, 32'd3, 32'd10, 32'd3, 32'd0, 1'b0, 0);

    // Flush on the 5th RUN cycle of a divide: nothing may come out.
    issue(2'b10, 32'd100, 32'd7);
    repeat (4) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_idle", {62'd0, in_ready, busy}, 64'd2);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("flush_no_result", {63'd0, seen}, 64'd0);
    @(posedge clk); #1;
    flush = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    check("flush_blocks_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_no_accept", {63'd0, busy}, 64'd0);
    run_op(2'b00, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 0);

    // Result held for 10 cycles with out_ready low.
    run_op(2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 10);

    // Asynchronous reset in the middle of RUN.
    issue(2'b00, 32'd9, 32'd9);
    repeat (3) @(posedge clk);
    #3;
    check("busy_mid_run", {63'd0, busy}, 64'd1);
    resetn = 1'b0;
    #1;
    check("async_reset_flags", {62'd0, out_valid, busy}, 64'd0);
    check("async_reset_data", {hi, lo}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("ready_after_reset", {63'd0, in_ready}, 64'd1);

    for (int n = 0; n < 40; n++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: ra = 32'($urandom_range(0, 255));
        3: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        4: rb = rb >> $urandom_range(0, 31);
        default: ;
      endcase
      r = ref_f(ro, ra, rb);
      run_op(ro, ra, rb, r[63:32], r[31:0], 1'b1, 0);
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
